arbitro_mux8: RTL and testbench
===============================

# arbitro_mux8

Round-robin arbiter and scheduler for the 8-source, 8-bit data multiplexer. It grants one of eight requesters at a time and drives the multiplexer's 3-bit select. It presents the selected stream to a single consumer through a valid/ready handshake. Each grant is held for a bounded burst of transfers, then passes fairly to the next requester.

## Interface
- BURST_MAX, default 4: maximum transfers per grant; legal range 1..255.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- Req  in  8  Req[i]=1: requester i has a valid word on data input Di.
- Ready  in  1  consumer can accept the word on the multiplexer output this cycle.
- Lock  in  1  present only with ARB_LOCK_EN; current grantee requests burst-limit bypass.
- Sel  out  3  select for the data multiplexer (index of the current or last grantee).
- Gnt  out  8  one-hot grant; all zero when idle.
- Valid  out  1  multiplexer output holds a valid word for the consumer.
- Pop  out  8  one-hot; Pop[i]=1 when requester i's word transfers this cycle.

## Operation
- Reset (Rst_n=0 at an edge) sets: state IDLE, Gnt=0, Sel=0, rotation pointer Ptr=0, burst count Cnt=0.
- While Rst_n=0, Valid=0 and Pop=0 combinationally.
- Reset mid-burst drops the grant with no further Pop.
- States: IDLE and GRANT.
- Winner selection: first index i with Req[i]=1, searching Ptr, Ptr+1, …, Ptr+7 (mod 8).
- IDLE:
  - Gnt=0, Valid=0; Sel holds its last value.
  - If any Req bit is 1 at an edge: load Gnt=onehot(winner), Sel=winner, Cnt=0, go to GRANT.
- GRANT:
  - Valid = Req[Sel], combinational.
  - Transfer = Valid & Ready.
  - Pop = Gnt when Transfer=1, else 0.
  - Each transfer increments Cnt (8-bit).
- Release condition, evaluated at each edge in GRANT:
  - (a) Transfer=1 and Cnt+1 == BURST_MAX, or
  - (b) Req[Sel]=0.
- On release:
  - Ptr <= Sel+1 (mod 8; 7 wraps to 0).
  - Arbitration runs in the same edge using the current Req, with requester Sel's own bit treated as that edge's value.
  - If a winner exists: reload Gnt, Sel, Cnt=0, stay in GRANT. This is a zero-bubble handoff.
  - If no winner: go to IDLE.
- A sole requester can regain the grant immediately after its burst, because the search wraps back to it.
- Gnt and Sel change only at grant or release edges, never within a burst.
- Ready is ignored when Valid=0; Req is not required to be stable, but dropping it releases the grant.

## Timing
- Req rise at edge k while IDLE → Gnt/Sel valid after edge k; Valid may be 1 in cycle k+1; first Pop can occur in cycle k+1. Latency: 1 cycle.
- Handoff: last transfer of a burst at edge t → new Gnt/Sel after edge t, new Valid in cycle t+1, with no idle cycle.
- Sustained throughput with Ready=1 and all Req=1: one word per cycle; the grant rotates every BURST_MAX cycles.
- Sel, Gnt: registered. Valid, Pop: combinational from registered state, Req and Ready (no register stage).

## Configuration
- Macro: ARB_LOCK_EN.
- Defined:
  - Lock port exists.
  - In GRANT with Lock=1, release condition (a) is suppressed and Cnt saturates at BURST_MAX.
  - Release then occurs only on Req[Sel]=0, or at the first transfer with Lock=0 after Cnt has reached BURST_MAX-1 or more.
- Undefined: no Lock port; bursts are always limited by BURST_MAX.

## Test plan
- Reset check: Rst_n=0 for 2 cycles with Req=8'hFF → Gnt=0, Sel=0, Valid=0, Pop=0. After release, first Gnt=8'h01.
- Rotation, BURST_MAX=4, Req=8'hFF, Ready=1 → Pop pattern: 4× 8'h01, 4× 8'h02, …, 4× 8'h80, then 8'h01 again, with no gap cycles.
- Backpressure: Req=8'h10, Ready toggling 1,0,1,0 → Valid=1 throughout; Pop=8'h10 only on Ready=1 cycles. Grant releases after the 4th Pop, not after the 4th cycle.
- Early drop: grant on requester 3 with Req=8'h88; Req[3]→0 after 2 Pops → next edge Gnt=8'h80, Sel=7. Then Ptr wraps, and the following winner search starts at 0.
- Sole requester: Req=8'h04 only, Ready=1 → continuous Pop=8'h04 every cycle across burst boundaries; Gnt stays 8'h04.
- With ARB_LOCK_EN defined: Lock=1 while requester 0 is granted and Req=8'h03 → 10 consecutive Pop=8'h01. After Lock drops, one more Pop, then Gnt=8'h02.

Source files
------------

// File: rtl/arbitro_mux8.sv
// Round-robin arbiter/scheduler for an 8-source data multiplexer with bounded bursts.
// Optional build macro ARB_LOCK_EN adds a lock input that lets the grantee bypass the burst limit.
module arbitro_mux8 #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ready,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       valid,
    output logic [7:0] pop
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    logic [0:0] state_reg, state_next;
    logic [7:0] gnt_reg,   gnt_next;
    logic [2:0] sel_reg,   sel_next;
    logic [2:0] ptr_reg,   ptr_next;
    logic [7:0] cnt_reg,   cnt_next;

    logic       lock_act;
    logic       transfer;
    logic       burst_done;
    logic       release_grant;
    logic [2:0] base;
    logic [7:0] rot_req;
    logic [2:0] win_off;
    logic [2:0] winner;
    logic       win_found;

`ifdef ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    assign valid    = rst_n && (state_reg == GRANT) && req[sel_reg];
    assign transfer = valid && ready;
    assign pop      = transfer ? gnt_reg : 8'h00;

    // Compare as 9 bits so a saturated count of 255 cannot wrap past the limit.
    assign burst_done    = ({1'b0, cnt_reg} + 9'd1) >= {1'b0, BURST_LIM};
    assign release_grant = (state_reg == GRANT) &&
                           (!req[sel_reg] || (transfer && !lock_act && burst_done));

    // On release the search starts just past the outgoing grantee, which is
    // exactly the pointer value being written at that same edge.
    assign base = (state_reg == GRANT) ? sel_reg + 3'd1 : ptr_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[base + 3'(gi)];
        end
    endgenerate

    always_comb begin
        win_found = |rot_req;
        win_off   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) win_off = 3'(i);
        end
        winner = base + win_off;
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        if (state_reg == IDLE) begin
            if (win_found) begin
                state_next = GRANT;
                gnt_next   = 8'b1 << winner;
                sel_next   = winner;
                cnt_next   = 8'd0;
            end
        end else begin
            if (release_grant) begin
                ptr_next = sel_reg + 3'd1;
                if (win_found) begin
                    gnt_next = 8'b1 << winner;
                    sel_next = winner;
                    cnt_next = 8'd0;
                end else begin
                    state_next = IDLE;
                    gnt_next   = 8'h00;
                end
            end else if (transfer) begin
                // Only a locked burst can reach the limit without releasing; hold it there.
                cnt_next = (cnt_reg >= BURST_LIM) ? cnt_reg : cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= 8'h00;
            sel_reg   <= 3'd0;
            ptr_reg   <= 3'd0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign gnt = gnt_reg;
    assign sel = sel_reg;

endmodule

// File: tb/tb_arbitro_mux8.sv
// Randomised + directed bench for arbitro_mux8; a queue-based scoreboard is fed by a
// transaction-level arbitration model and drained by an independent negedge monitor.
module tb_arbitro_mux8;

    localparam int BM = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       ready;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       valid;
    logic [7:0] pop;

    arbitro_mux8 #(.BURST_MAX(BM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid),
        .pop   (pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic [7:0] pop;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: current grantee (-1 = none), last select,
    // search start and transfers made in the current grant.
    int m_g     = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_burst = 0;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %02h expected %02h", name, c, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rd, input logic lk, input logic rn);
        exp_t e;
        logic lk_eff;
        logic xfer;
        int   w;
        req   = r;
        ready = rd;
        rst_n = rn;
`ifdef ARB_LOCK_EN
        lock   = lk;
        lk_eff = lk;
`else
        lk_eff = 1'b0 & lk;
`endif
        e.gnt   = (m_g >= 0) ? 8'(1 << m_g) : 8'h00;
        e.sel   = 3'(m_sel);
        e.valid = rn && (m_g >= 0) && r[m_g];
        e.pop   = (e.valid && rd) ? 8'(1 << m_g) : 8'h00;
        e.cyc   = cyc;
        sb_q.push_back(e);
        $display("cyc %0d rst_n=%0b req=%02h ready=%0b lock=%0b -> exp gnt=%02h sel=%0d valid=%0b pop=%02h",
                 cyc, rn, r, rd, lk_eff, e.gnt, e.sel, e.valid, e.pop);
        xfer = e.valid && rd;
        if (!rn) begin
            m_g = -1; m_sel = 0; m_ptr = 0; m_burst = 0;
        end else if (m_g < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_g = w; m_sel = w; m_burst = 0;
            end
        end else begin
            if (xfer) m_burst++;
            if (!r[m_g] || (xfer && !lk_eff && m_burst >= BM)) begin
                m_ptr = (m_g + 1) % 8;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_g = w; m_sel = w; m_burst = 0;
                end else begin
                    m_g = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("gnt",   e.cyc, gnt,            e.gnt);
            chk("sel",   e.cyc, {5'd0, sel},    {5'd0, e.sel});
            chk("valid", e.cyc, {7'd0, valid},  {7'd0, e.valid});
            chk("pop",   e.cyc, pop,            e.pop);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        ready = 1'b0;
`ifdef ARB_LOCK_EN
        lock  = 1'b0;
`endif
        @(posedge clk);
        #1;

        // Reset held with all requests active
        repeat (2) step(8'hFF, 1'b1, 1'b0, 1'b0);
        // Full rotation with continuous ready
        repeat (36) step(8'hFF, 1'b1, 1'b0, 1'b1);
        // Backpressure on a single requester
        step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(8'h10, (i % 2) == 1, 1'b0, 1'b1);
        // Early drop then pointer wrap
        step(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) step(8'h88, 1'b1, 1'b0, 1'b1);
        repeat (3) step(8'h80, 1'b1, 1'b0, 1'b1);
        repeat (6) step(8'h81, 1'b1, 1'b0, 1'b1);
        // Sole requester across burst boundaries
        step(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (14) step(8'h04, 1'b1, 1'b0, 1'b1);
        // Lock held on requester 0, then dropped
        step(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (11) step(8'h03, 1'b1, 1'b1, 1'b1);
        repeat (5) step(8'h03, 1'b1, 1'b0, 1'b1);
        // Mid-burst reset drops the grant
        repeat (2) step(8'hFF, 1'b1, 1'b0, 1'b1);
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (3) step(8'hFF, 1'b1, 1'b0, 1'b1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) != 0));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
